// File: rtl/cpu_clock_gen_pkg.sv
// Shared constants and state encoding for the glitch-free 68SEC000 clock switcher.
package cpu_clock_gen_pkg;

    localparam int unsigned CNT_W       = 21;
    localparam int unsigned INIT_CYCLES = 3;
    localparam int unsigned INIT_W      = 2;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_SLOW     = 3'd1,
        ST_TO_TURBO = 3'd2,
        ST_TURBO    = 3'd3,
        ST_TO_SLOW  = 3'd4
    } clk_state_e;

endpackage

// File: rtl/cpu_clock_gen_sync2.sv
// Two-flop synchroniser for a single asynchronous control bit.
module cpu_clock_gen_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/cpu_clock_gen.sv
// CPU clock generator: debounced turbo jumper, turbo divider and a switcher that
// only changes source while the bus is idle and CLKCPU is low.
module cpu_clock_gen
    import cpu_clock_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 2000000,
    parameter int unsigned TURBO_HALF     = 1
) (
    input  logic pll_inst1_CLKOUT0,
    input  logic RESET_n,
    input  logic JP1,
    input  logic C7M,
    input  logic AS_CPU_n,
    input  logic DTACK_CPU_n,
    output logic CLKCPU,
    output logic CPU_SPEED_SWITCH,
    output logic SWITCH_BUSY
);

    localparam int unsigned        TDIV_W    = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;
    localparam logic [TDIV_W-1:0]  TDIV_LAST = TDIV_W'(TURBO_HALF - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    logic              w_jp1_s;
    logic              w_c7_s;
    logic              w_idle_s;
    logic              w_idle_raw;
    logic              w_c7_rise;
    logic              w_c7_fall;
    logic              w_tdiv_last;
    logic              w_tphase_fall;
    logic              w_init_done;
    logic              w_clkcpu_nxt;
    clk_state_e        w_state_nxt;

    logic              r_c7_d;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tgt;
    logic [TDIV_W-1:0] r_tdiv;
    logic              r_tphase;
    logic [INIT_W-1:0] r_init_cnt;
    clk_state_e        r_state;
    logic              r_clkcpu;
    logic              r_speed;
    logic              r_busy;

    assign w_idle_raw = AS_CPU_n & DTACK_CPU_n;

    cpu_clock_gen_sync2 u_sync_jp1  (.i_clk(pll_inst1_CLKOUT0), .i_rst_n(RESET_n), .i_d(JP1),        .o_q(w_jp1_s));
    cpu_clock_gen_sync2 u_sync_c7   (.i_clk(pll_inst1_CLKOUT0), .i_rst_n(RESET_n), .i_d(C7M),        .o_q(w_c7_s));
    cpu_clock_gen_sync2 u_sync_idle (.i_clk(pll_inst1_CLKOUT0), .i_rst_n(RESET_n), .i_d(w_idle_raw), .o_q(w_idle_s));

    assign w_c7_rise     = w_c7_s & ~r_c7_d;
    assign w_c7_fall     = ~w_c7_s & r_c7_d;
    assign w_tdiv_last   = (r_tdiv == TDIV_LAST);
    // Last cycle of a turbo high phase: tphase falls on this edge.
    assign w_tphase_fall = r_tphase & w_tdiv_last;

    // Next state and next CLKCPU level.
    always_comb begin
        w_state_nxt  = r_state;
        w_clkcpu_nxt = 1'b0;
        w_init_done  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_init_done = 1'b1;
                    w_state_nxt = w_jp1_s ? ST_TO_TURBO : ST_SLOW;
                end
            end
            ST_SLOW: begin
                w_clkcpu_nxt = w_c7_s;
                if (r_tgt && w_idle_s && !w_c7_s && !w_c7_rise)
                    w_state_nxt = ST_TO_TURBO;
            end
            ST_TO_TURBO: begin
                if (w_tdiv_last)
                    w_state_nxt = ST_TURBO;
            end
            ST_TURBO: begin
                w_clkcpu_nxt = r_tphase;
                if (!r_tgt && w_idle_s && w_tphase_fall)
                    w_state_nxt = ST_TO_SLOW;
            end
            ST_TO_SLOW: begin
                if (w_c7_fall)
                    w_state_nxt = ST_SLOW;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_c7_d     <= 1'b0;
            r_clkcpu   <= 1'b0;
            r_speed    <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= (r_state == ST_INIT && !w_init_done) ? r_init_cnt + INIT_W'(1) : '0;
            r_c7_d     <= w_c7_s;
            r_clkcpu   <= w_clkcpu_nxt;
            r_speed    <= (w_state_nxt == ST_TURBO) || (w_state_nxt == ST_TO_SLOW);
            r_busy     <= (w_state_nxt == ST_INIT) || (w_state_nxt == ST_TO_TURBO) ||
                          (w_state_nxt == ST_TO_SLOW);
        end
    end

    // JP1 debounce; INIT exit loads the target directly.
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            r_cnt <= '0;
            r_tgt <= 1'b0;
        end else if (w_init_done) begin
            r_cnt <= '0;
            r_tgt <= w_jp1_s;
        end else if (w_jp1_s != r_tgt) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_tgt <= w_jp1_s;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Divider doubles as the TO_TURBO low-stretch counter; cleared on TURBO entry.
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            r_tdiv   <= '0;
            r_tphase <= 1'b0;
        end else if (r_state == ST_TO_TURBO && w_state_nxt == ST_TURBO) begin
            r_tdiv   <= '0;
            r_tphase <= 1'b0;
        end else if (r_state == ST_TO_TURBO || r_state == ST_TURBO) begin
            if (w_tdiv_last) begin
                r_tdiv <= '0;
                if (r_state == ST_TURBO)
                    r_tphase <= ~r_tphase;
            end else begin
                r_tdiv <= r_tdiv + TDIV_W'(1);
            end
        end else begin
            r_tdiv   <= '0;
            r_tphase <= 1'b0;
        end
    end

    assign CLKCPU           = r_clkcpu;
    assign CPU_SPEED_SWITCH = r_speed;
    assign SWITCH_BUSY      = r_busy;

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Bench for cpu_clock_gen: behavioural reference compared every cycle, plus directed pins.
`timescale 1ns/1ps
module tb_cpu_clock_gen;

    localparam int LIM   = 16;
    localparam int TH    = 2;
    localparam int MINPW = 2;

    localparam int M_INIT = 0;
    localparam int M_SLOW = 1;
    localparam int M_UP   = 2;
    localparam int M_FAST = 3;
    localparam int M_DOWN = 4;

    logic clk;
    logic RESET_n;
    logic JP1;
    logic C7M;
    logic AS_CPU_n;
    logic DTACK_CPU_n;
    logic CLKCPU;
    logic CPU_SPEED_SWITCH;
    logic SWITCH_BUSY;

    int n_chk  = 0;
    int n_fail = 0;
    bit c7_en  = 1'b1;
    bit pw_en  = 1'b0;
    bit cmp_en = 1'b0;

    cpu_clock_gen #(
        .DEBOUNCE_LIMIT(LIM),
        .TURBO_HALF    (TH)
    ) dut (
        .pll_inst1_CLKOUT0(clk),
        .RESET_n          (RESET_n),
        .JP1              (JP1),
        .C7M              (C7M),
        .AS_CPU_n         (AS_CPU_n),
        .DTACK_CPU_n      (DTACK_CPU_n),
        .CLKCPU           (CLKCPU),
        .CPU_SPEED_SWITCH (CPU_SPEED_SWITCH),
        .SWITCH_BUSY      (SWITCH_BUSY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ~7 MHz motherboard clock with jitter; never toggles on a clk rising edge.
    initial begin : c7_gen
        int d;
        C7M = 1'b0;
        forever begin
            if (c7_en) begin
                d = int'($urandom_range(66, 75));
                if ((($time + d) % 10) == 5) d = d + 1;
                #d C7M = ~C7M;
            end else begin
                C7M = 1'b0;
                @(negedge clk);
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: sync delays as history arrays, turbo as a position in the period.
    int m_mode, m_init_left, m_run, m_left, m_pos;
    bit m_tgt, m_clk, m_spd, m_busy;
    bit jp_p[2];
    bit id_p[2];
    bit c7_p[3];

    task model_reset();
        m_mode = M_INIT; m_init_left = 3; m_run = 0; m_left = 0; m_pos = 0;
        m_tgt = 1'b0; m_clk = 1'b0; m_spd = 1'b0; m_busy = 1'b1;
        jp_p = '{1'b0, 1'b0};
        id_p = '{1'b0, 1'b0};
        c7_p = '{1'b0, 1'b0, 1'b0};
    endtask

    task model_step();
        bit jp1_s, c7_s, c7_d, idle_s, tgt_old;
        int nxt;
        jp1_s = jp_p[1]; c7_s = c7_p[1]; c7_d = c7_p[2]; idle_s = id_p[1];
        tgt_old = m_tgt;
        nxt = m_mode;
        m_clk = 1'b0;
        if (jp1_s != m_tgt) begin
            if (m_run == LIM - 1) begin m_tgt = jp1_s; m_run = 0; end
            else m_run++;
        end else begin
            m_run = 0;
        end
        case (m_mode)
            M_INIT: begin
                if (m_init_left == 1) begin
                    m_tgt = jp1_s; m_run = 0; m_left = TH;
                    nxt = jp1_s ? M_UP : M_SLOW;
                end else begin
                    m_init_left--;
                end
            end
            M_SLOW: begin
                m_clk = c7_s;
                if (tgt_old && idle_s && !c7_s) begin nxt = M_UP; m_left = TH; end
            end
            M_UP: begin
                m_left--;
                if (m_left == 0) begin nxt = M_FAST; m_pos = 0; end
            end
            M_FAST: begin
                m_clk = (m_pos >= TH);
                if (!tgt_old && idle_s && m_pos == 2 * TH - 1) nxt = M_DOWN;
                m_pos = (m_pos + 1) % (2 * TH);
            end
            default: begin
                if (!c7_s && c7_d) nxt = M_SLOW;
            end
        endcase
        m_mode = nxt;
        m_spd  = (nxt == M_FAST) || (nxt == M_DOWN);
        m_busy = (nxt == M_INIT) || (nxt == M_UP) || (nxt == M_DOWN);
        jp_p[1] = jp_p[0]; jp_p[0] = JP1;
        id_p[1] = id_p[0]; id_p[0] = AS_CPU_n & DTACK_CPU_n;
        c7_p[2] = c7_p[1]; c7_p[1] = c7_p[0]; c7_p[0] = C7M;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge RESET_n);
            if (!RESET_n) model_reset();
            else          model_step();
        end
    end

    // Per-cycle compare against the model, plus a minimum pulse-width watch on CLKCPU.
    logic pw_last = 1'b0;
    int   pw_run  = 0;
    bit   pw_armed = 1'b0;

    initial begin : compare
        forever begin
            @(negedge clk);
            #2;
            if (cmp_en) begin
                chk("clkcpu_model", CLKCPU, m_clk);
                chk("speed_model", CPU_SPEED_SWITCH, m_spd);
                chk("busy_model", SWITCH_BUSY, m_busy);
                if (!RESET_n || !pw_en) pw_armed = 1'b0;
                if (CLKCPU == pw_last) begin
                    pw_run++;
                end else begin
                    if (pw_armed) begin
                        n_chk++;
                        if (pw_run < MINPW) begin
                            n_fail++;
                            $display("FAIL pulse_width at %0t: got %0d clk expected >= %0d", $time, pw_run, MINPW);
                        end
                    end
                    pw_armed = pw_en && RESET_n;
                    pw_run   = 1;
                end
                pw_last = CLKCPU;
            end
        end
    end

    initial begin : main
        int hold;
        RESET_n = 1'b1; JP1 = 1'b0; AS_CPU_n = 1'b1; DTACK_CPU_n = 1'b1;
        #3 RESET_n = 1'b0;
        tick(3);
        cmp_en = 1'b1;
        chk("rst_clkcpu", CLKCPU, 1'b0);
        chk("rst_speed", CPU_SPEED_SWITCH, 1'b0);
        chk("rst_busy", SWITCH_BUSY, 1'b1);

        // Reset release, JP1=0: three INIT cycles then SLOW.
        RESET_n = 1'b1;
        tick(1); chk("init0_busy_c1", SWITCH_BUSY, 1'b1); chk("init0_clk_c1", CLKCPU, 1'b0);
        tick(1); chk("init0_busy_c2", SWITCH_BUSY, 1'b1);
        tick(1); chk("init0_busy_c3", SWITCH_BUSY, 1'b0); chk("init0_speed", CPU_SPEED_SWITCH, 1'b0);

        // Bounces shorter than the limit are ignored; a stable level is accepted after LIM+2.
        c7_en = 1'b0;
        tick(12);
        repeat (3) begin
            JP1 = 1'b1; tick(10);
            JP1 = 1'b0; tick(10);
        end
        chk("bounce_busy", SWITCH_BUSY, 1'b0);
        chk("bounce_speed", CPU_SPEED_SWITCH, 1'b0);
        JP1 = 1'b1;
        tick(LIM + 2); chk("deb_not_early", SWITCH_BUSY, 1'b0);
        tick(1);       chk("deb_start", SWITCH_BUSY, 1'b1);
        tick(TH);      chk("deb_turbo", CPU_SPEED_SWITCH, 1'b1);

        // Reset release, JP1=1: INIT, TH cycles of TO_TURBO, then divided clock.
        RESET_n = 1'b0; c7_en = 1'b1;
        tick(2);
        RESET_n = 1'b1;
        tick(3);  chk("init1_busy", SWITCH_BUSY, 1'b1); chk("init1_speed_lo", CPU_SPEED_SWITCH, 1'b0);
        tick(TH); chk("init1_speed_hi", CPU_SPEED_SWITCH, 1'b1); chk("init1_busy_lo", SWITCH_BUSY, 1'b0);
        tick(TH + 1); chk("turbo_high", CLKCPU, 1'b1);
        tick(TH);     chk("turbo_low", CLKCPU, 1'b0);

        // Turbo->slow waits for idle, then holds low until a C7M fall; reset mid-switch.
        c7_en = 1'b0; AS_CPU_n = 1'b0; JP1 = 1'b0;
        tick(40);
        chk("busy_hold_speed", CPU_SPEED_SWITCH, 1'b1);
        chk("busy_hold_busy", SWITCH_BUSY, 1'b0);
        AS_CPU_n = 1'b1;
        tick(10);
        chk("toslow_busy", SWITCH_BUSY, 1'b1);
        chk("toslow_clk", CLKCPU, 1'b0);
        chk("toslow_speed", CPU_SPEED_SWITCH, 1'b1);
        RESET_n = 1'b0;
        #1;
        chk("midrst_clk", CLKCPU, 1'b0);
        chk("midrst_speed", CPU_SPEED_SWITCH, 1'b0);
        chk("midrst_busy", SWITCH_BUSY, 1'b1);
        tick(2);
        RESET_n = 1'b1; c7_en = 1'b1;
        tick(5);
        chk("post_rst_busy", SWITCH_BUSY, 1'b0);
        chk("post_rst_speed", CPU_SPEED_SWITCH, 1'b0);

        // Random jumper, bus activity and C7M phase stress.
        tick(20);
        pw_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            JP1  = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(4, 60));
            repeat (hold) begin
                if ($urandom_range(0, 7) == 0) AS_CPU_n = ~AS_CPU_n;
                if ($urandom_range(0, 3) == 0) DTACK_CPU_n = 1'($urandom_range(0, 1));
                tick(1);
            end
        end
        pw_en = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
